reg_write_once_ctrl: RTL
========================

Name: reg_write_once_ctrl

Overview:
Upstream write controller for a bank of write-once lock registers. It accepts single-beat read/write requests over a valid/ready request channel and returns results over a valid/ready response channel. It decodes the address and drives a per-register write strobe plus shared write data into the downstream write-once registers. It keeps a shadow copy of each register's lock bit, so a write to a locked register is rejected with an error instead of being issued.

Parameters:
DATA_W, 16, width of register data; bit 0 is the lock bit
NUM_REGS, 4, number of downstream write-once registers
ADDR_W, 3, request address width; must satisfy 2**ADDR_W >= NUM_REGS

Ports:
Clk  input  1  single clock, rising edge
ip_reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  register index
req_wdata  input  DATA_W  write data
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts the response
resp_err  output  1  1 = rejected (locked register or bad address)
resp_rdata  output  DATA_W  read data; 0 for writes and errors
reg_write  output  NUM_REGS  one-hot write strobe to the downstream registers
reg_wdata  output  DATA_W  shared write data to the downstream registers
reg_rdata  input  NUM_REGS*DATA_W  flattened downstream Data_out values; register i occupies bits [i*DATA_W +: DATA_W]
lock_status  output  NUM_REGS  shadow lock bits

Behaviour:
- Reset is synchronous, active-high, on Clk. On reset:
  - state = IDLE
  - req_ready = 0 during the reset cycle, 1 on the first cycle after release
  - resp_valid = 0, resp_err = 0, resp_rdata = 0
  - reg_write = 0, reg_wdata = 0, lock_status = 0
- Reset mid-operation aborts the transaction: no strobe, no response, all shadow locks cleared. The downstream registers are reset by their own reset.
- FSM states: IDLE, ISSUE, SETTLE, RESP.
- req_ready = 1 only in IDLE. A request is accepted on an edge where req_valid & req_ready. Address, data and direction are captured at that edge.
- IDLE, valid write, addr < NUM_REGS and lock_status[addr] = 0 -> ISSUE.
- IDLE, write with addr >= NUM_REGS, or lock_status[addr] = 1 -> RESP with resp_err = 1. No strobe is driven.
- IDLE, read with addr < NUM_REGS -> RESP. resp_rdata takes the reg_rdata slice sampled at the accept edge; resp_err = 0.
- IDLE, read with addr >= NUM_REGS -> RESP with resp_err = 1 and resp_rdata = 0.
- ISSUE (exactly 1 cycle):
  - reg_write[addr] = 1, all other strobe bits 0
  - reg_wdata = captured data
  - lock_status[addr] is set at the exiting edge if wdata[0] = 1
  - -> SETTLE
- SETTLE (exactly 1 cycle): reg_write = 0, reg_wdata held -> RESP with resp_err = 0. The downstream register is level-sensitive, so data must stay stable for one cycle after the strobe falls.
- RESP: resp_valid = 1; resp_err and resp_rdata stay stable until resp_valid & resp_ready. On that edge -> IDLE and resp_valid falls. New requests cannot be accepted in the same cycle.
- Latency, accept at edge T:
  - good write: strobe in cycle T+1, resp_valid from cycle T+3
  - read or error: resp_valid from cycle T+1
- reg_wdata holds its last value in IDLE and RESP. Only ISSUE updates it.
- Lock bits are sticky and can only be cleared by ip_reset.
- A write of 0 to bit 0 of an unlocked register is issued normally and leaves it unlocked.
- Back-to-back writes to the same register: the second write sees the lock set by the first.
- Any resp_ready value is legal outside RESP and is ignored there.

Decomposition:
- Package reg_write_once_pkg:
  - state enum typedef (IDLE/ISSUE/SETTLE/RESP)
  - LOCK_BIT = 0
- One natural sub-module, reg_write_once_lock_tracker:
  - holds the NUM_REGS shadow lock bits
  - set input, index input and synchronous reset
  - combinational locked[addr] lookup output
- The FSM, address decode and datapath stay in the top module.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset; req_ready = 1 on the first cycle after release; lock_status = 4'b0000.
- Write addr 2, data 16'hA5A5, resp_ready = 1 -> reg_write = 4'b0100 for 1 cycle in T+1; reg_wdata = 16'hA5A5 during T+1 and T+2; resp_valid in T+3 with err = 0; lock_status = 4'b0100.
- Second write addr 2, data 16'h1234 -> no strobe at any cycle; resp_err = 1 in T+1; reg_wdata stays 16'hA5A5.
- Write addr 5 (>= NUM_REGS) -> resp_err = 1, no strobe. Read addr 1 with reg_rdata slice 1 = 16'h00F0 -> resp_rdata = 16'h00F0, err = 0.
- Read response with resp_ready held 0 for 4 cycles -> resp_valid, resp_err and resp_rdata stable and req_ready = 0 throughout; returns to IDLE one cycle after resp_ready rises.
- Write addr 0, data 16'h0001, with ip_reset asserted during SETTLE -> no response; lock_status = 0 after reset; a following write to addr 0 is issued, not rejected.

Source files
------------

// File: rtl/reg_write_once_pkg.sv
// Shared types and constants for the write-once register controller.
package reg_write_once_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Bit of the register data that locks it once written as 1.
    localparam int LOCK_BIT = 0;

endpackage

// File: rtl/reg_write_once_lock_tracker.sv
// Shadow copy of the downstream lock bits: sticky set, cleared only by reset.
module reg_write_once_lock_tracker
    import reg_write_once_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set,
    input  logic [ADDR_W-1:0]   idx,
    output logic                locked,
    output logic [NUM_REGS-1:0] lock_status
);

    localparam int              IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

    logic [NUM_REGS-1:0] lock_q;
    logic                in_range;
    logic [IDX_W-1:0]    sel;

    assign in_range    = ({1'b0, idx} < NREGS);
    assign sel         = idx[IDX_W-1:0];
    // Out-of-range indices never report locked; the top rejects them anyway.
    assign locked      = in_range & lock_q[sel];
    assign lock_status = lock_q;

    // Sticky lock bits; only a synchronous reset clears them.
    always_ff @(posedge clk) begin
        if (rst)
            lock_q <= '0;
        else if (set && in_range)
            lock_q[sel] <= 1'b1;
    end

endmodule

// File: rtl/reg_write_once_ctrl.sv
// Request/response front end for a bank of write-once lock registers.
// Writes to locked or nonexistent registers are rejected without a strobe.
module reg_write_once_ctrl
    import reg_write_once_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 3
) (
    input  logic                       Clk,
    input  logic                       ip_reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp_err,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic [NUM_REGS-1:0]        reg_write,
    output logic [DATA_W-1:0]          reg_wdata,
    input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
    output logic [NUM_REGS-1:0]        lock_status
);

    localparam int              IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

    state_e                           state;
    logic [ADDR_W-1:0]                cap_addr;
    logic                             cap_lock;
    logic                             accept;
    logic                             addr_ok;
    logic                             locked;
    logic                             lk_set;
    logic [ADDR_W-1:0]                lk_idx;
    logic [IDX_W-1:0]                 sel;
    logic [NUM_REGS-1:0]              dec;
    logic [NUM_REGS-1:0][DATA_W-1:0]  rdata_arr;

    assign rdata_arr = reg_rdata;
    assign sel       = req_addr[IDX_W-1:0];
    assign addr_ok   = ({1'b0, req_addr} < NREGS);
    assign dec       = {{(NUM_REGS-1){1'b0}}, 1'b1} << sel;
    assign req_ready = (state == IDLE) & ~ip_reset;
    assign accept    = req_valid & req_ready;

    // Lookup uses the live address while idle; the set uses the captured one.
    assign lk_idx = (state == ISSUE) ? cap_addr : req_addr;
    assign lk_set = (state == ISSUE) & cap_lock;

    reg_write_once_lock_tracker #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_lock (
        .clk         (Clk),
        .rst         (ip_reset),
        .set         (lk_set),
        .idx         (lk_idx),
        .locked      (locked),
        .lock_status (lock_status)
    );

    // Control FSM with registered response and strobe outputs.
    always_ff @(posedge Clk) begin
        if (ip_reset) begin
            state      <= IDLE;
            cap_addr   <= '0;
            cap_lock   <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            reg_write  <= '0;
            reg_wdata  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cap_addr <= req_addr;
                    cap_lock <= req_wdata[LOCK_BIT];
                    if (req_write) begin
                        if (addr_ok && !locked) begin
                            state     <= ISSUE;
                            reg_write <= dec;
                            reg_wdata <= req_wdata;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= ~addr_ok;
                        resp_rdata <= addr_ok ? rdata_arr[sel] : '0;
                    end
                end
                ISSUE: begin
                    // Data stays on reg_wdata through SETTLE for the latch.
                    reg_write <= '0;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
